// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: sequences the shared memory port, ALU and
// datapath registers one state per cycle, with a memory-ready handshake,
// a stall watchdog that halts the machine, and a per-instruction retire pulse.
module main_fsm #(
    parameter int STALL_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       memReady,
    output logic       memReq,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] immSrc,
    output logic       instRet,
    output logic       illegalOp,
    output logic       memTimeout
);

    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    localparam logic [6:0] OP_LW   = 7'd3;
    localparam logic [6:0] OP_SW   = 7'd35;
    localparam logic [6:0] OP_R    = 7'd51;
    localparam logic [6:0] OP_I    = 7'd19;
    localparam logic [6:0] OP_BEQ  = 7'd99;
    localparam logic [6:0] OP_JAL  = 7'd111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_cnt_next;
    logic             mem_wait;
    logic             timeout_hit;
    logic             timeout_q;

    // Watchdog: count consecutive not-ready cycles in a memory state; the
    // cycle that would bring the count to STALL_LIMIT is the timeout cycle.
    // A ready cycle never times out because mem_wait requires !memReady.
    always_comb begin
        mem_wait       = ((state == S_FETCH) || (state == S_MEMREAD) ||
                          (state == S_MEMWRITE)) && !memReady;
        timeout_hit    = mem_wait && (int'(stall_cnt) == STALL_LIMIT - 1);
        stall_cnt_next = mem_wait ? stall_cnt + CNT_W'(1) : '0;
    end

    // State register, stall counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign memTimeout = timeout_q;

    // Next-state and control outputs; enables are forced low while reset is
    // high so in-flight writes drop without waiting for a clock edge.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case below can infer a latch.
        state_next = state;
        memReq     = 1'b0;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = 2'b00;
        aluSrcA    = 2'b00;
        aluSrcB    = 2'b00;
        aluOp      = 2'b00;
        instRet    = 1'b0;
        illegalOp  = 1'b0;

        case (state)
            S_FETCH: begin
                memReq    = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = memReady;
                pcWrite   = memReady;
                if (memReady) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        state_next = S_FETCH;
                        illegalOp  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA    = 2'b10;
                aluSrcB    = 2'b01;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
                if (memReady) begin
                    state_next = S_MEMWB;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_MEMWB: begin
                resultSrc  = 2'b01;
                regWrite   = 1'b1;
                instRet    = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                memReq   = 1'b1;
                adrSrc   = 1'b1;
                memWrite = memReady;
                instRet  = memReady;
                if (memReady) begin
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_EXECR: begin
                aluSrcA    = 2'b10;
                aluOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA    = 2'b10;
                aluSrcB    = 2'b01;
                aluOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite   = 1'b1;
                instRet    = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                aluSrcA    = 2'b10;
                aluOp      = 2'b01;
                pcWrite    = zero;
                instRet    = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                aluSrcA    = 2'b01;
                aluSrcB    = 2'b10;
                pcWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (reset) begin
            memReq    = 1'b0;
            memWrite  = 1'b0;
            irWrite   = 1'b0;
            pcWrite   = 1'b0;
            regWrite  = 1'b0;
            instRet   = 1'b0;
            illegalOp = 1'b0;
        end
    end

    // Immediate format select, decoded straight from the opcode.
    always_comb begin
        case (op)
            OP_SW:   immSrc = 2'b01;
            OP_BEQ:  immSrc = 2'b10;
            OP_JAL:  immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: each scenario pushes the per-cycle
// expected control vector to a scoreboard queue and a negedge monitor pops
// and compares it against the DUT outputs.
module tb_main_fsm;

    localparam int STALL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       memReady = 1'b0;
    logic       memReq, adrSrc, memWrite, irWrite, pcWrite, regWrite;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;
    logic       instRet, illegalOp, memTimeout;

    int tests = 0;
    int failed = 0;

    typedef logic [16:0] vec_t;
    typedef struct {
        vec_t  exp;
        string tag;
    } item_t;

    item_t exp_q[$];
    logic  rdy_q[$];
    vec_t  act_vec;
    item_t mon_it;

    main_fsm #(.STALL_LIMIT(STALL)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memReady(memReady),
        .memReq(memReq), .adrSrc(adrSrc), .memWrite(memWrite),
        .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite),
        .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluOp(aluOp), .immSrc(immSrc), .instRet(instRet),
        .illegalOp(illegalOp), .memTimeout(memTimeout)
    );

    always #5 clk = ~clk;

    assign act_vec = {memReq, adrSrc, memWrite, irWrite, pcWrite, regWrite,
                      resultSrc, aluSrcA, aluSrcB, aluOp,
                      instRet, illegalOp, memTimeout};

    function automatic vec_t v(input logic mreq, adr, mw, irw, pcw, rw,
                               input logic [1:0] rs, sa, sb, ao,
                               input logic ir, il, mt);
        return {mreq, adr, mw, irw, pcw, rw, rs, sa, sb, ao, ir, il, mt};
    endfunction

    // Expected output vectors per state, straight from the state table.
    function automatic vec_t e_fetch(input logic r);
        return v(1, 0, 0, r, r, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    endfunction
    function automatic vec_t e_decode(input logic il);
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, il, 0);
    endfunction
    function automatic vec_t e_memadr();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
    endfunction
    function automatic vec_t e_memread();
        return v(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    endfunction
    function automatic vec_t e_memwb();
        return v(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    endfunction
    function automatic vec_t e_memwrite(input logic r);
        return v(1, 1, r, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, r, 0, 0);
    endfunction
    function automatic vec_t e_execr();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0);
    endfunction
    function automatic vec_t e_execi();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0);
    endfunction
    function automatic vec_t e_aluwb();
        return v(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    endfunction
    function automatic vec_t e_beq(input logic z);
        return v(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0, 0);
    endfunction
    function automatic vec_t e_jal();
        return v(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0);
    endfunction
    function automatic vec_t e_halt();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    endfunction
    function automatic vec_t e_reset();
        return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    endfunction

    // Scoreboard monitor: one expected vector consumed per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_it = exp_q.pop_front();
            tests++;
            if (act_vec !== mon_it.exp) begin
                failed++;
                $display("FAIL %s: got %b expected %b", mon_it.tag, act_vec, mon_it.exp);
            end
        end
    end

    task automatic add(input logic r, input vec_t e, input string tag);
        rdy_q.push_back(r);
        exp_q.push_back('{exp: e, tag: tag});
    endtask

    // Plays queued memReady values, one per cycle; called at posedge+1.
    task automatic drain();
        while (rdy_q.size() > 0) begin
            memReady = rdy_q.pop_front();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        memReady = 1'b1;
        @(posedge clk);
        #1;
        add(1, e_reset(), "reset_hold");
        drain();
        reset = 1'b0;
        #1;
        tests++;
        if (immSrc !== 2'b00) begin
            failed++;
            $display("FAIL reset_immsrc: got %b expected 00", immSrc);
        end
    endtask

    task automatic test_add();
        op = 7'd51;
        add(1, e_fetch(1), "add_fetch");
        add(1, e_decode(0), "add_decode");
        add(1, e_execr(), "add_execr");
        add(1, e_aluwb(), "add_aluwb");
        drain();
    endtask

    task automatic test_lw_stall();
        op = 7'd3;
        #1;
        tests++;
        if (immSrc !== 2'b00) begin
            failed++;
            $display("FAIL lw_immsrc: got %b expected 00", immSrc);
        end
        add(1, e_fetch(1), "lw_fetch");
        add(1, e_decode(0), "lw_decode");
        add(1, e_memadr(), "lw_memadr");
        add(0, e_memread(), "lw_memread_w1");
        add(0, e_memread(), "lw_memread_w2");
        add(1, e_memread(), "lw_memread_rdy");
        add(1, e_memwb(), "lw_memwb");
        drain();
    endtask

    task automatic test_sw_stall();
        op = 7'd35;
        #1;
        tests++;
        if (immSrc !== 2'b01) begin
            failed++;
            $display("FAIL sw_immsrc: got %b expected 01", immSrc);
        end
        add(1, e_fetch(1), "sw_fetch");
        add(1, e_decode(0), "sw_decode");
        add(1, e_memadr(), "sw_memadr");
        for (int i = 0; i < STALL - 1; i++) add(0, e_memwrite(0), "sw_memwrite_wait");
        add(1, e_memwrite(1), "sw_memwrite_rdy_at_limit");
        drain();
    endtask

    task automatic test_beq();
        op = 7'd99;
        #1;
        tests++;
        if (immSrc !== 2'b10) begin
            failed++;
            $display("FAIL beq_immsrc: got %b expected 10", immSrc);
        end
        zero = 1'b1;
        add(1, e_fetch(1), "beq_t_fetch");
        add(1, e_decode(0), "beq_t_decode");
        add(1, e_beq(1), "beq_taken");
        drain();
        zero = 1'b0;
        add(1, e_fetch(1), "beq_n_fetch");
        add(1, e_decode(0), "beq_n_decode");
        add(1, e_beq(0), "beq_not_taken");
        drain();
    endtask

    task automatic test_jal();
        op = 7'd111;
        #1;
        tests++;
        if (immSrc !== 2'b11) begin
            failed++;
            $display("FAIL jal_immsrc: got %b expected 11", immSrc);
        end
        add(1, e_fetch(1), "jal_fetch");
        add(1, e_decode(0), "jal_decode");
        add(1, e_jal(), "jal_jal");
        add(1, e_aluwb(), "jal_aluwb");
        drain();
    endtask

    task automatic test_addi();
        op = 7'd19;
        add(1, e_fetch(1), "addi_fetch");
        add(1, e_decode(0), "addi_decode");
        add(1, e_execi(), "addi_execi");
        add(1, e_aluwb(), "addi_aluwb");
        drain();
    endtask

    task automatic test_back_to_back_illegal();
        op = 7'h7F;
        add(1, e_fetch(1), "ill_fetch1");
        add(1, e_decode(1), "ill_decode1");
        add(1, e_fetch(1), "ill_fetch2");
        add(1, e_decode(1), "ill_decode2");
        drain();
    endtask

    task automatic test_fetch_stall();
        op = 7'd51;
        for (int i = 0; i < STALL - 1; i++) add(0, e_fetch(0), "fst_fetch_wait");
        add(1, e_fetch(1), "fst_fetch_rdy");
        add(1, e_decode(0), "fst_decode");
        add(1, e_execr(), "fst_execr");
        add(1, e_aluwb(), "fst_aluwb");
        drain();
    endtask

    task automatic test_reset_mid_memwrite();
        op = 7'd35;
        add(1, e_fetch(1), "rmw_fetch");
        add(1, e_decode(0), "rmw_decode");
        add(1, e_memadr(), "rmw_memadr");
        drain();
        add(1, e_memwrite(1), "rmw_memwrite");
        memReady = rdy_q.pop_front();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({memWrite, memReq, instRet, irWrite, pcWrite, regWrite} !== 6'b0) begin
            failed++;
            $display("FAIL rmw_async_drop: got %b expected 000000",
                     {memWrite, memReq, instRet, irWrite, pcWrite, regWrite});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        op = 7'd51;
        add(1, e_fetch(1), "rmw_resume_fetch");
        add(1, e_decode(0), "rmw_resume_decode");
        add(1, e_execr(), "rmw_resume_execr");
        add(1, e_aluwb(), "rmw_resume_aluwb");
        drain();
    endtask

    task automatic test_timeout();
        op = 7'd51;
        for (int i = 0; i < STALL; i++) add(0, e_fetch(0), "to_fetch_wait");
        for (int i = 0; i < 3; i++) add(1, e_halt(), "to_halt");
        drain();
        reset = 1'b1;
        add(1, e_reset(), "to_reset_hold");
        drain();
        reset = 1'b0;
        add(1, e_fetch(1), "to_resume_fetch");
        add(1, e_decode(0), "to_resume_decode");
        add(1, e_execr(), "to_resume_execr");
        add(1, e_aluwb(), "to_resume_aluwb");
        drain();
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_jal();
        test_addi();
        test_back_to_back_illegal();
        test_fetch_stall();
        test_reset_mid_memwrite();
        test_timeout();
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drained: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
